mem_responder: RTL and testbench

Unified instruction/data memory that services the multicycle core controller's memory requests over a valid/ready request and one-cycle response-pulse interface. It sits on the far side of the controller's address mux and accepts both instruction fetches and load/store accesses. It handles byte, halfword and word widths using the RISC-V funct3 encoding, with little-endian byte lanes and sign/zero extension on loads. Latency is parameterised, so the controller's wait states can be exercised against both fast and slow memory.

---
 rtl/mem_responder_if.sv | 23 ++
 rtl/mem_responder.sv | 150 +++++++++++++++
 tb/tb_mem_responder.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// Request/response bus between the core's memory controller (master) and the
// unified memory responder (slave): valid/ready request, one-cycle response pulse.
interface mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [2:0]  req_size;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_size, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_size, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mem_responder.sv
// Unified instruction/data memory with parameterised latency and B/H/W lane access.
// Optional feature: define MISALIGN_CHECK_EN to flag misaligned H/W accesses as errors.
module mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 1
) (
  input  logic           clk,
  input  logic           rst,
  mem_responder_if.slave bus
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     addr_q, addr_d;
  logic [2:0]      size_q, size_d;
  logic            write_q, write_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [31:0]     rsp_rdata_q, rsp_rdata_d;
  logic            rsp_err_q, rsp_err_d;
  logic            mem_we;

  logic [31:0]     mem [DEPTH_WORDS];
  logic [AW-1:0]   idx;
  logic [31:0]     word_rd;
  logic            size_ok, in_range, misalign, acc_err;

  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  lane,
                                               input logic [2:0]  size);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      3'd0:    load_extract = {{24{b[7]}}, b};
      3'd1:    load_extract = {{16{h[15]}}, h};
      3'd4:    load_extract = {24'b0, b};
      3'd5:    load_extract = {16'b0, h};
      default: load_extract = word;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] word,
                                              input logic [1:0]  lane,
                                              input logic [2:0]  size,
                                              input logic [31:0] wdata);
    logic [31:0] r;
    r = word;
    case (size)
      3'd0: r[{lane, 3'b000} +: 8] = wdata[7:0];
      3'd1: begin
        if (lane[1]) r[31:16] = wdata[15:0];
        else         r[15:0]  = wdata[15:0];
      end
      default: r = wdata;
    endcase
    return r;
  endfunction

  // Access decode works from the captured request, so the bus may change while busy.
  assign idx      = addr_q[AW+1:2];
  assign word_rd  = mem[idx];
  assign size_ok  = (size_q == 3'd0) || (size_q == 3'd1) || (size_q == 3'd2) ||
                    (!write_q && ((size_q == 3'd4) || (size_q == 3'd5)));
  assign in_range = ({2'b00, addr_q[31:2]} < 32'(DEPTH_WORDS));
`ifdef MISALIGN_CHECK_EN
  assign misalign = ((size_q[1:0] == 2'd1) && addr_q[0]) ||
                    ((size_q == 3'd2) && (addr_q[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif
  assign acc_err  = !size_ok || !in_range || misalign;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    size_d      = size_q;
    write_d     = write_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    mem_we      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          addr_d  = bus.req_addr;
          size_d  = bus.req_size;
          write_d = bus.req_write;
          wdata_d = bus.req_wdata;
          cnt_d   = CW'(LATENCY - 1);
          state_d = (LATENCY == 1) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= CW'(1)) state_d = S_RESP;
      end
      S_RESP: begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = acc_err;
        rsp_rdata_d = (acc_err || write_q) ? 32'h0 : load_extract(word_rd, addr_q[1:0], size_q);
        mem_we      = write_q && !acc_err;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    size_q  <= size_d;
    write_q <= write_d;
    wdata_q <= wdata_d;
  end

  // Contents survive reset; mem_we drops as soon as rst forces IDLE.
  always_ff @(posedge clk) begin
    if (mem_we) mem[idx] <= store_merge(word_rd, addr_q[1:0], size_q, wdata_q);
  end

  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Table-driven scoreboard bench for mem_responder at LATENCY 1 and LATENCY 4.
module tb_mem_responder;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_responder_if i1 ();
  mem_responder_if i4 ();

  logic        sel;
  logic        drv_valid, drv_write;
  logic [31:0] drv_addr, drv_wdata;
  logic [2:0]  drv_size;

  assign i1.req_valid = drv_valid & ~sel;
  assign i1.req_write = drv_write;
  assign i1.req_addr  = drv_addr;
  assign i1.req_size  = drv_size;
  assign i1.req_wdata = drv_wdata;
  assign i4.req_valid = drv_valid & sel;
  assign i4.req_write = drv_write;
  assign i4.req_addr  = drv_addr;
  assign i4.req_size  = drv_size;
  assign i4.req_wdata = drv_wdata;

  wire        m_ready  = sel ? i4.req_ready : i1.req_ready;
  wire        m_rvalid = sel ? i4.rsp_valid : i1.rsp_valid;
  wire [31:0] m_rdata  = sel ? i4.rsp_rdata : i1.rsp_rdata;
  wire        m_err    = sel ? i4.rsp_err   : i1.rsp_err;

  mem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) dut1 (.clk(clk), .rst(rst), .bus(i1));
  mem_responder #(.DEPTH_WORDS(1024), .LATENCY(4)) dut4 (.clk(clk), .rst(rst), .bus(i4));

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        is_wr;
    int          id;
  } exp_t;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  sz;
    logic [31:0] wd;
    logic [31:0] er;
    logic        ee;
  } vec_t;

  exp_t sb[$];
  vec_t vt[$];
  int   checks = 0;
  int   passes = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  task automatic add(input logic wr, input logic [31:0] a, input logic [2:0] sz,
                     input logic [31:0] wd, input logic [31:0] er, input logic ee);
    vec_t v;
    v.wr = wr; v.addr = a; v.sz = sz; v.wd = wd; v.er = er; v.ee = ee;
    vt.push_back(v);
  endtask

  task automatic txn(input logic s, input logic wr, input logic [31:0] a, input logic [2:0] sz,
                     input logic [31:0] wd, input logic [31:0] er, input logic ee,
                     input int id, input logic junk);
    exp_t e;
    int   lat;
    int   k;
    logic busy_ok;
    lat = s ? 4 : 1;
    @(negedge clk);
    sel = s; drv_valid = 1'b1; drv_write = wr; drv_addr = a; drv_size = sz; drv_wdata = wd;
    e.rdata = er; e.err = ee; e.is_wr = wr; e.id = id;
    sb.push_back(e);
    k = 0;
    while (!m_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!m_ready) begin
      chk($sformatf("t%0d_accept_timeout", id), 32'(m_ready), 32'h1);
      drv_valid = 1'b0;
      void'(sb.pop_front());
      return;
    end
    @(posedge clk);
    @(negedge clk);
    if (junk) begin
      drv_write = 1'b1;
      drv_wdata = ~wd;
    end else begin
      drv_valid = 1'b0;
    end
    busy_ok = 1'b1;
    k = 0;
    while (!m_rvalid && k < lat + 10) begin
      if (m_ready) busy_ok = 1'b0;
      if (k == lat - 1) drv_valid = 1'b0;
      @(negedge clk);
      k++;
    end
    drv_valid = 1'b0;
    chk($sformatf("t%0d_busy_ready_low", id), 32'(busy_ok), 32'h1);
    chk($sformatf("t%0d_latency", id), 32'(k), 32'(lat));
    e = sb.pop_front();
    if (m_rvalid) begin
      chk($sformatf("t%0d_err", e.id), 32'(m_err), 32'(e.err));
      if (!e.is_wr) chk($sformatf("t%0d_rdata", e.id), m_rdata, e.rdata);
      @(negedge clk);
      chk($sformatf("t%0d_pulse", e.id), 32'(m_rvalid), 32'h0);
      chk($sformatf("t%0d_hold", e.id), m_rdata, e.is_wr ? m_rdata : e.rdata);
    end else begin
      chk($sformatf("t%0d_rsp_timeout", e.id), 32'(m_rvalid), 32'h1);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1);
  end

  initial begin
    logic seen;
    sel = 1'b0; drv_valid = 1'b0; drv_write = 1'b0;
    drv_addr = 32'h0; drv_size = 3'd2; drv_wdata = 32'h0;

    #2 rst = 1'b1;
    #1;
    chk("rst_ready1",  32'(i1.req_ready), 32'h1);
    chk("rst_rvalid1", 32'(i1.rsp_valid), 32'h0);
    chk("rst_rdata1",  i1.rsp_rdata,      32'h0);
    chk("rst_err1",    32'(i1.rsp_err),   32'h0);
    chk("rst_ready4",  32'(i4.req_ready), 32'h1);
    chk("rst_rvalid4", 32'(i4.rsp_valid), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    add(1, 32'h10,   3'd2, 32'hDEADBEEF, 32'h0,        0);
    add(0, 32'h10,   3'd2, 32'h0,        32'hDEADBEEF, 0);
    add(1, 32'h20,   3'd2, 32'h0,        32'h0,        0);
    add(1, 32'h21,   3'd0, 32'h000000F0, 32'h0,        0);
    add(0, 32'h20,   3'd2, 32'h0,        32'h0000F000, 0);
    add(0, 32'h21,   3'd0, 32'h0,        32'hFFFFFFF0, 0);
    add(0, 32'h21,   3'd4, 32'h0,        32'h000000F0, 0);
    add(1, 32'h30,   3'd2, 32'hAAAA5555, 32'h0,        0);
    add(1, 32'h32,   3'd1, 32'h00008001, 32'h0,        0);
    add(0, 32'h32,   3'd1, 32'h0,        32'hFFFF8001, 0);
    add(0, 32'h32,   3'd5, 32'h0,        32'h00008001, 0);
    add(0, 32'h30,   3'd2, 32'h0,        32'h80015555, 0);
    add(0, 32'h33,   3'd0, 32'h0,        32'hFFFFFF80, 0);
    add(0, 32'h30,   3'd4, 32'h0,        32'h00000055, 0);
    add(0, 32'h1000, 3'd2, 32'h0,        32'h0,        1);
    add(1, 32'h1000, 3'd2, 32'h5A5A5A5A, 32'h0,        1);
    add(0, 32'h10,   3'd3, 32'h0,        32'h0,        1);
    add(0, 32'h10,   3'd6, 32'h0,        32'h0,        1);
    add(1, 32'h10,   3'd4, 32'h00000000, 32'h0,        1);
    add(1, 32'h10,   3'd5, 32'h00000000, 32'h0,        1);
    add(0, 32'h10,   3'd2, 32'h0,        32'hDEADBEEF, 0);
    add(1, 32'hFFC,  3'd2, 32'h01020304, 32'h0,        0);
    add(0, 32'hFFC,  3'd2, 32'h0,        32'h01020304, 0);
`ifdef MISALIGN_CHECK_EN
    add(0, 32'h11,   3'd2, 32'h0,        32'h0,        1);
    add(0, 32'h33,   3'd1, 32'h0,        32'h0,        1);
    add(0, 32'h31,   3'd5, 32'h0,        32'h0,        1);
`else
    add(0, 32'h11,   3'd2, 32'h0,        32'hDEADBEEF, 0);
    add(0, 32'h33,   3'd1, 32'h0,        32'hFFFF8001, 0);
    add(0, 32'h31,   3'd5, 32'h0,        32'h00005555, 0);
`endif

    foreach (vt[i])
      txn(1'b0, vt[i].wr, vt[i].addr, vt[i].sz, vt[i].wd, vt[i].er, vt[i].ee, i, 1'b0);

    // Slow memory: busy-period requests must be ignored.
    txn(1'b1, 1'b1, 32'h10, 3'd2, 32'hCAFEF00D, 32'h0,        1'b0, 100, 1'b0);
    txn(1'b1, 1'b0, 32'h10, 3'd2, 32'h0,        32'hCAFEF00D, 1'b0, 101, 1'b1);
    txn(1'b1, 1'b0, 32'h10, 3'd2, 32'h0,        32'hCAFEF00D, 1'b0, 102, 1'b0);
    txn(1'b1, 1'b1, 32'h40, 3'd2, 32'h11111111, 32'h0,        1'b0, 103, 1'b0);

    // Reset in WAIT aborts the store.
    @(negedge clk);
    sel = 1'b1; drv_valid = 1'b1; drv_write = 1'b1;
    drv_addr = 32'h40; drv_size = 3'd2; drv_wdata = 32'h12345678;
    chk("abort_ready_before", 32'(m_ready), 32'h1);
    @(posedge clk);
    @(negedge clk);
    drv_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_ready_async",  32'(i4.req_ready), 32'h1);
    chk("abort_rvalid_async", 32'(i4.rsp_valid), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (i4.rsp_valid) seen = 1'b1;
    end
    chk("abort_no_rsp", 32'(seen), 32'h0);
    txn(1'b1, 1'b0, 32'h40, 3'd2, 32'h0, 32'h11111111, 1'b0, 104, 1'b0);
    txn(1'b0, 1'b0, 32'h10, 3'd2, 32'h0, 32'hDEADBEEF, 1'b0, 105, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
